// File: rtl/snn_pkg.sv
// Shared types, default parameters and signed saturation helper for the spiking core.
package snn_pkg;

    localparam int unsigned N_IN_DEF       = 16;
    localparam int unsigned N_HID_DEF      = 8;
    localparam int unsigned N_OUT_DEF      = 10;
    localparam int unsigned W_W_DEF        = 8;
    localparam int unsigned V_W_DEF        = 16;
    localparam int unsigned THRESH_DEF     = 64;
    localparam int unsigned LEAK_SHIFT_DEF = 3;
    localparam int unsigned REFRAC_DEF     = 2;
    localparam int unsigned T_WIN_DEF      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC_IN,
        S_FIRE,
        S_ACC_OUT,
        S_ARGMAX,
        S_EMIT
    } state_e;

    // Adds two sign-extended operands and clamps to the signed range of a w-bit word (w <= 31).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -hi - 33'sd1;
        if (sum > hi) begin
            return 32'(hi);
        end else if (sum < lo) begin
            return 32'(lo);
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// One leaky-integrate-and-fire neuron: per-step input accumulator, membrane and refractory counter.
module snn_lif_neuron
    import snn_pkg::*;
#(
    parameter int unsigned W_W        = W_W_DEF,
    parameter int unsigned V_W        = V_W_DEF,
    parameter int unsigned THRESH     = THRESH_DEF,
    parameter int unsigned LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int unsigned REFRAC     = REFRAC_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  add_en_i,
    input  logic signed [W_W-1:0] add_val_i,
    input  logic                  fire_i,
    output logic                  spike_o
);

    localparam int unsigned R_W = $clog2(REFRAC + 1) + 1;
    localparam logic signed [V_W-1:0] TH = V_W'(THRESH);

    logic signed [V_W-1:0] acc_q, acc_d;
    logic signed [V_W-1:0] v_q, v_d;
    logic signed [V_W-1:0] v_leak, v_sum;
    logic [R_W-1:0]        refr_q, refr_d;
    logic                  spike_q, spike_d;

    always_comb begin
        acc_d   = acc_q;
        v_d     = v_q;
        refr_d  = refr_q;
        spike_d = spike_q;
        // Membrane never goes negative, so the leak subtraction cannot overflow.
        v_leak  = v_q - (v_q >>> LEAK_SHIFT);
        v_sum   = V_W'(sat_add(32'(v_leak), 32'(acc_q), V_W));

        if (clr_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            acc_d = V_W'(sat_add(32'(acc_q), 32'(add_val_i), V_W));
        end

        if (fire_i) begin
            if (refr_q != '0) begin
                v_d     = '0;
                refr_d  = refr_q - R_W'(1);
                spike_d = 1'b0;
            end else if (v_sum >= TH) begin
                v_d     = '0;
                refr_d  = R_W'(REFRAC);
                spike_d = 1'b1;
            end else begin
                v_d     = v_sum[V_W-1] ? '0 : v_sum;
                spike_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            v_q     <= v_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;

endmodule

// File: rtl/snn_lif_core.sv
// Two-layer time-stepped spiking core: LIF hidden layer, integrating output scores,
// windowed argmax readout and a run-time weight write port.
module snn_lif_core
    import snn_pkg::*;
#(
    parameter int unsigned N_IN       = N_IN_DEF,
    parameter int unsigned N_HID      = N_HID_DEF,
    parameter int unsigned N_OUT      = N_OUT_DEF,
    parameter int unsigned W_W        = W_W_DEF,
    parameter int unsigned V_W        = V_W_DEF,
    parameter int unsigned THRESH     = THRESH_DEF,
    parameter int unsigned LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int unsigned REFRAC     = REFRAC_DEF,
    parameter int unsigned T_WIN      = T_WIN_DEF
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic [N_IN-1:0]                                   in_spikes,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic                                              w_we,
    input  logic                                              w_layer,
    input  logic [$clog2((N_IN > N_HID) ? N_IN : N_HID)-1:0]  w_row,
    input  logic [$clog2((N_HID > N_OUT) ? N_HID : N_OUT)-1:0] w_col,
    input  logic signed [W_W-1:0]                             w_data,
    output logic                                              busy,
    output logic [N_HID-1:0]                                  hidden_spikes,
    output logic                                              hid_valid,
    output logic [N_OUT-1:0]                                  cmd_onehot,
    output logic [$clog2(N_OUT)-1:0]                          cmd_idx,
    output logic                                              cmd_none,
    output logic                                              cmd_valid
);

    localparam int unsigned MAX_IH = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int unsigned MAX_N  = (MAX_IH > N_OUT) ? MAX_IH : N_OUT;
    localparam int unsigned CNT_W  = $clog2(MAX_N);
    localparam int unsigned IDX_W  = $clog2(N_OUT);
    localparam int unsigned STEP_W = (T_WIN > 1) ? $clog2(T_WIN) : 1;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [STEP_W-1:0]     step_q;
    logic [N_IN-1:0]       spk_in_q;
    logic signed [W_W-1:0] w_in_q  [N_IN][N_HID];
    logic signed [W_W-1:0] w_out_q [N_HID][N_OUT];
    logic signed [V_W-1:0] score_q [N_OUT];
    logic signed [V_W-1:0] score_d [N_OUT];
    logic signed [V_W-1:0] best_val_q, best_val_d, cur_score;
    logic [IDX_W-1:0]      best_idx_q, best_idx_d;
    logic                  best_pos_d;
    logic [N_OUT-1:0]      onehot_d;

    logic                  hid_valid_q, cmd_valid_q, cmd_none_q;
    logic [IDX_W-1:0]      cmd_idx_q;
    logic [N_OUT-1:0]      cmd_onehot_q;

    logic                  in_bit, hid_bit, accept, fire, acc_in_en;
    logic signed [W_W-1:0] row_in  [N_HID];
    logic signed [W_W-1:0] row_out [N_OUT];
    logic [N_HID-1:0]      hid_spk;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_ready && in_valid;
    assign fire      = (state_q == S_FIRE);
    assign acc_in_en = (state_q == S_ACC_IN) && in_bit;

    // Row/element selection by the shared step counter, used by the three serial phases.
    always_comb begin
        in_bit    = 1'b0;
        hid_bit   = 1'b0;
        cur_score = '0;
        for (int unsigned j = 0; j < N_HID; j++) row_in[j] = '0;
        for (int unsigned k = 0; k < N_OUT; k++) row_out[k] = '0;

        for (int unsigned i = 0; i < N_IN; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                in_bit = spk_in_q[i];
                for (int unsigned j = 0; j < N_HID; j++) row_in[j] = w_in_q[i][j];
            end
        end
        for (int unsigned j = 0; j < N_HID; j++) begin
            if (cnt_q == CNT_W'(j)) begin
                hid_bit = hid_spk[j];
                for (int unsigned k = 0; k < N_OUT; k++) row_out[k] = w_out_q[j][k];
            end
        end
        for (int unsigned k = 0; k < N_OUT; k++) begin
            score_d[k] = V_W'(sat_add(32'(score_q[k]), 32'(row_out[k]), V_W));
            if (cnt_q == CNT_W'(k)) cur_score = score_q[k];
        end

        // Running maximum starts at zero, so only strictly positive scores can win.
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (cur_score > best_val_q) begin
            best_val_d = cur_score;
            best_idx_d = cnt_q[IDX_W-1:0];
        end
        best_pos_d = !best_val_d[V_W-1] && (best_val_d != '0);
        for (int unsigned k = 0; k < N_OUT; k++) begin
            onehot_d[k] = best_pos_d && (best_idx_d == IDX_W'(k));
        end
    end

    for (genvar j = 0; j < N_HID; j++) begin : g_hid
        snn_lif_neuron #(
            .W_W        (W_W),
            .V_W        (V_W),
            .THRESH     (THRESH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_neuron (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr_i     (accept),
            .add_en_i  (acc_in_en),
            .add_val_i (row_in[j]),
            .fire_i    (fire),
            .spike_o   (hid_spk[j])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            spk_in_q     <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            hid_valid_q  <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_none_q   <= 1'b0;
            cmd_idx_q    <= '0;
            cmd_onehot_q <= '0;
            for (int unsigned i = 0; i < N_IN; i++)
                for (int unsigned j = 0; j < N_HID; j++) w_in_q[i][j] <= '0;
            for (int unsigned j = 0; j < N_HID; j++)
                for (int unsigned k = 0; k < N_OUT; k++) w_out_q[j][k] <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) score_q[k] <= '0;
        end else begin
            hid_valid_q <= 1'b0;
            cmd_valid_q <= 1'b0;

            if (w_we && (state_q == S_IDLE)) begin
                for (int unsigned i = 0; i < N_IN; i++)
                    for (int unsigned j = 0; j < N_HID; j++)
                        if (!w_layer && 32'(w_row) == i && 32'(w_col) == j) w_in_q[i][j] <= w_data;
                for (int unsigned j = 0; j < N_HID; j++)
                    for (int unsigned k = 0; k < N_OUT; k++)
                        if (w_layer && 32'(w_row) == j && 32'(w_col) == k) w_out_q[j][k] <= w_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        spk_in_q <= in_spikes;
                        cnt_q    <= '0;
                        state_q  <= S_ACC_IN;
                    end
                end
                S_ACC_IN: begin
                    if (cnt_q == CNT_W'(N_IN - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_FIRE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIRE: begin
                    hid_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= S_ACC_OUT;
                end
                S_ACC_OUT: begin
                    if (hid_bit) begin
                        for (int unsigned k = 0; k < N_OUT; k++) score_q[k] <= score_d[k];
                    end
                    if (cnt_q == CNT_W'(N_HID - 1)) begin
                        cnt_q <= '0;
                        if (step_q < STEP_W'(T_WIN - 1)) begin
                            step_q  <= step_q + STEP_W'(1);
                            state_q <= S_IDLE;
                        end else begin
                            best_val_q <= '0;
                            best_idx_q <= '0;
                            state_q    <= S_ARGMAX;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ARGMAX: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    // The last element's comparison feeds the result registers directly.
                    if (cnt_q == CNT_W'(N_OUT - 1)) begin
                        cnt_q        <= '0;
                        cmd_valid_q  <= 1'b1;
                        cmd_none_q   <= !best_pos_d;
                        cmd_idx_q    <= best_idx_d;
                        cmd_onehot_q <= onehot_d;
                        state_q      <= S_EMIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    for (int unsigned k = 0; k < N_OUT; k++) score_q[k] <= '0;
                    step_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hidden_spikes = hid_spk;
    assign hid_valid     = hid_valid_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_none      = cmd_none_q;
    assign cmd_idx       = cmd_idx_q;
    assign cmd_onehot    = cmd_onehot_q;

endmodule
